mux_n_pipe: RTL and testbench

//  Parametrised, registered N-way datapath selector with valid/ready flow control.

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_n_pipe_if.sv | 31 +++
 rtl/mux_skid_stage.sv | 75 +++++++
 rtl/mux_n_pipe.sv | 73 +++++++
 tb/tb_mux_n_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way selector: occupancy encodings,
// error-counter width and the parameter sanity check used at elaboration.
package mux_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int ERRO_CNT_W = 8;

    function automatic bit sel_w_ok(input int sel_w, input int n_inputs);
        return ((2 ** sel_w) >= n_inputs) && (n_inputs >= 2) && (n_inputs <= 16);
    endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Producer/consumer bundle of the selector: master is the surrounding logic,
// slave is the mux_n_pipe block.
interface mux_n_pipe_if
    import mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int N_INPUTS = 11,
    parameter int SEL_W    = 4
) ();

    logic [N_INPUTS*WIDTH-1:0] entradas;
    logic [SEL_W-1:0]          controle;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          saida;
    logic                      out_valid;
    logic                      out_ready;
    logic                      erro_sel;
    logic [ERRO_CNT_W-1:0]     erro_cnt;

    modport master (
        output entradas, controle, in_valid, out_ready,
        input  in_ready, saida, out_valid, erro_sel, erro_cnt
    );

    modport slave (
        input  entradas, controle, in_valid, out_ready,
        output in_ready, saida, out_valid, erro_sel, erro_cnt
    );

endinterface

// File: rtl/mux_skid_stage.sv
// Two-entry skid buffer with fully registered valid/ready; in_ready never
// depends combinationally on out_ready.
module mux_skid_stage
    import mux_pkg::*;
#(
    parameter int           W           = 17,
    parameter logic [W-1:0] RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         xfer;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= OCC_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            // NOTE: both data registers are reset because out_data is visible
            // (and must read RESET_VALUE) even while no beat is valid.
            out_data  <= RESET_VALUE;
            skid_data <= RESET_VALUE;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && !xfer) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= OCC_FULL;
                    end else if (xfer && !accept) begin
                        out_valid <= 1'b0;
                        state     <= OCC_EMPTY;
                    end else if (accept && xfer) begin
                        out_data  <= in_data;
                    end
                end
                OCC_FULL: begin
                    if (xfer) begin
                        out_data  <= skid_data;
                        in_ready  <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                default: begin
                    state     <= OCC_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way selector: picks one input word per accepted beat, substitutes
// the last in-range word for out-of-range selects, and counts those errors.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               N_INPUTS    = 11,
    parameter int               SEL_W       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         reset,
    mux_n_pipe_if.slave  bus
);

    if (!sel_w_ok(SEL_W, N_INPUTS)) begin : g_bad_params
        $error("mux_n_pipe: SEL_W too narrow or N_INPUTS outside 2..16");
    end

    logic [WIDTH-1:0]      held_word;
    logic [WIDTH-1:0]      sel_word;
    logic                  in_range;
    logic [ERRO_CNT_W-1:0] erro_cnt_q;
    logic                  accept;
    logic [WIDTH:0]        head;

    // NOTE: defaults first so every path through the loop assigns both
    // outputs and no latch is inferred.
    always_comb begin
        sel_word = held_word;
        in_range = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (bus.controle == SEL_W'(k)) begin
                sel_word = bus.entradas[k*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            held_word  <= RESET_VALUE;
            erro_cnt_q <= '0;
        end else if (accept) begin
            if (in_range) begin
                held_word <= sel_word;
            end else if (erro_cnt_q != '1) begin
                erro_cnt_q <= erro_cnt_q + 1'b1;
            end
        end
    end

    mux_skid_stage #(
        .W           (WIDTH + 1),
        .RESET_VALUE ({1'b0, RESET_VALUE})
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({!in_range, sel_word}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head)
    );

    assign bus.saida    = head[WIDTH-1:0];
    assign bus.erro_sel = head[WIDTH];
    assign bus.erro_cnt = erro_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe with a scoreboard of expected beats built from
// an independent selection model.
module tb_mux_n_pipe;

    localparam int WIDTH    = 16;
    localparam int N_INPUTS = 11;
    localparam int SEL_W    = 4;

    logic clock;
    logic reset;

    mux_n_pipe_if #(.WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .SEL_W(SEL_W)) bus ();

    mux_n_pipe #(
        .WIDTH       (WIDTH),
        .N_INPUTS    (N_INPUTS),
        .SEL_W       (SEL_W),
        .RESET_VALUE ('0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] held_m = '0;
    int               cnt_m  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: inputs are stable at the falling edge and equal to what the
    // next rising edge samples.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            held_m = '0;
            cnt_m  = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_beat", 32'(bus.saida), 32'hFFFF_FFFF);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    check("sb_saida", 32'(bus.saida), 32'(e[WIDTH-1:0]));
                    check("sb_erro_sel", 32'(bus.erro_sel), 32'(e[WIDTH]));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                int c;
                c = int'(bus.controle);
                if (c < N_INPUTS) begin
                    held_m = bus.entradas[c*WIDTH +: WIDTH];
                    exp_q.push_back({1'b0, held_m});
                end else begin
                    exp_q.push_back({1'b1, held_m});
                    if (cnt_m < 255) cnt_m++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_inputs_default();
        for (int k = 0; k < N_INPUTS; k++)
            bus.entradas[k*WIDTH +: WIDTH] = 16'h1000 + 16'(k);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.controle  = '0;
        bus.out_ready = 1'b0;
        set_inputs_default();

        // 1: reset held two cycles with in_valid asserted
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_saida", 32'(bus.saida), 32'd0);
        check("rst_erro_sel", 32'(bus.erro_sel), 32'd0);
        check("rst_erro_cnt", 32'(bus.erro_cnt), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // 2: streaming at full rate
        bus.out_ready = 1'b1;
        for (int k = 0; k < N_INPUTS; k++) begin
            bus.controle = SEL_W'(k);
            bus.in_valid = 1'b1;
            tick();
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_saida", 32'(bus.saida), 32'h1000 + k);
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(bus.out_valid), 32'd0);
        check("stream_hold_saida", 32'(bus.saida), 32'h100A);

        // 3: backpressure fills the skid stage
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.controle  = 4'd3;
        tick();
        bus.controle  = 4'd5;
        tick();
        check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("bp_saida_3", 32'(bus.saida), 32'h1003);
        bus.controle  = 4'd7;
        bus.entradas[3*WIDTH +: WIDTH] = 16'h0BAD;
        tick();
        tick();
        check("bp_stable_saida", 32'(bus.saida), 32'h1003);
        check("bp_stable_valid", 32'(bus.out_valid), 32'd1);
        check("bp_stable_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_saida_5", 32'(bus.saida), 32'h1005);
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        tick();
        check("bp_saida_7", 32'(bus.saida), 32'h1007);
        bus.in_valid = 1'b0;
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        set_inputs_default();

        // 4: out-of-range select reuses the last in-range word
        bus.entradas[2*WIDTH +: WIDTH] = 16'hBEEF;
        bus.in_valid = 1'b1;
        bus.controle = 4'd2;
        tick();
        check("inv_first_saida", 32'(bus.saida), 32'hBEEF);
        check("inv_first_erro", 32'(bus.erro_sel), 32'd0);
        bus.controle = 4'hC;
        tick();
        check("inv_saida", 32'(bus.saida), 32'hBEEF);
        check("inv_erro_sel", 32'(bus.erro_sel), 32'd1);
        check("inv_erro_cnt", 32'(bus.erro_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            bus.controle = (i % 2 == 0) ? 4'hF : 4'hB;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check("inv_cnt_saturated", 32'(bus.erro_cnt), 32'd255);
        check("inv_cnt_model", 32'(bus.erro_cnt), 32'(cnt_m));
        set_inputs_default();

        // 5: accept and transfer together every cycle stays in ONE
        bus.in_valid = 1'b1;
        bus.controle = 4'd0;
        tick();
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < N_INPUTS; k++)
                bus.entradas[k*WIDTH +: WIDTH] = 16'($urandom);
            bus.controle = SEL_W'($urandom_range(0, N_INPUTS - 1));
            tick();
            check("one_in_ready", 32'(bus.in_ready), 32'd1);
            check("one_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        set_inputs_default();

        // 6: reset while FULL discards beats and clears the held word
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.controle  = 4'd4;
        tick();
        bus.controle  = 4'd6;
        tick();
        check("full_before_rst", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_saida", 32'(bus.saida), 32'd0);
        check("mid_rst_erro_cnt", 32'(bus.erro_cnt), 32'd0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        bus.controle  = 4'hD;
        tick();
        check("post_rst_saida", 32'(bus.saida), 32'd0);
        check("post_rst_erro_sel", 32'(bus.erro_sel), 32'd1);
        check("post_rst_erro_cnt", 32'(bus.erro_cnt), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
